// File: rtl/sc_pkg.sv
// Shared stochastic-computing definitions: default datapath width and the
// decoder FSM state encoding, used by both the SNG and the decoder sides.
package sc_pkg;

    localparam int unsigned SC_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sc_state_t;

endpackage

// File: rtl/sc_window_counter.sv
// WIDTH+1-bit up-counter with synchronous clear, count enable and a flag that
// marks the value one short of 2^WIDTH (the next enabled cycle completes a window).
module sc_window_counter
    import sc_pkg::*;
#(
    parameter int unsigned WIDTH = SC_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH:0]   count,
    output logic             terminal_c
);

    localparam logic [WIDTH:0] LAST = (WIDTH+1)'((1 << WIDTH) - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + (WIDTH+1)'(1);
        end
    end

    assign terminal_c = (count == LAST);

endmodule

// File: rtl/stoch_to_bin.sv
// Stochastic-to-binary decoder: counts ones over a window of 2^WIDTH valid
// stream bits and presents the saturated count as a WIDTH-bit estimate.
module stoch_to_bin
    import sc_pkg::*;
#(
    parameter int unsigned WIDTH = SC_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] value
);

    sc_state_t        state;
    sc_state_t        state_next;
    logic             clear;
    logic             win_en;
    logic             ones_en;
    logic             last_bit;
    logic             saturate;
    logic [WIDTH-1:0] value_next;
    logic [WIDTH:0]   win_count;
    logic [WIDTH:0]   ones_count;
    logic             win_term_c;
    logic             ones_term_c;
    logic             unused_win;

    sc_window_counter #(.WIDTH(WIDTH)) u_win_cnt (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .enable     (win_en),
        .count      (win_count),
        .terminal_c (win_term_c)
    );

    sc_window_counter #(.WIDTH(WIDTH)) u_ones_cnt (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .enable     (ones_en),
        .count      (ones_count),
        .terminal_c (ones_term_c)
    );

    // Window progress is tracked through the terminal flag alone.
    assign unused_win = ^win_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        clear      = 1'b0;
        win_en     = 1'b0;
        ones_en    = 1'b0;
        last_bit   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clear      = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (bit_valid) begin
                    win_en  = 1'b1;
                    ones_en = bit_in;
                    if (win_term_c) begin
                        last_bit   = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // The final bit is folded in here because it lands on the same edge as the load.
        saturate   = ones_count[WIDTH] | (ones_term_c & bit_in);
        value_next = saturate ? '1 : WIDTH'(ones_count + (WIDTH+1)'(bit_in));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            value <= '0;
        end else begin
            busy <= (state_next == RUN);
            done <= (state_next == DONE);
            if (last_bit) begin
                value <= value_next;
            end
        end
    end

endmodule

// File: doc/stoch_to_bin.md
STOCH_TO_BIN -- requirements
Module: stoch_to_bin

Interface
REQ-001 Parameter WIDTH, default 8: binary result width; the decoding window is 2^WIDTH stream bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin a new decoding window.
REQ-005 bit_in  input  1  stochastic bitstream from the SNG/circuit output (unipolar encoding).
REQ-006 bit_valid  input  1  bit_in is sampled only when high.
REQ-007 busy  output  1  high while a window is in progress.
REQ-008 done  output  1  one-cycle pulse when a window completes.
REQ-009 value  output  WIDTH  binary estimate of the last completed window; held until the next done.

Function
REQ-010 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-011 In IDLE, start=1 SHALL clear the ones-counter and the window counter and enter RUN on the next edge.
REQ-012 In RUN, each cycle with bit_valid=1 SHALL increment the window counter, and SHALL increment the ones-counter when bit_in=1.
REQ-013 Cycles with bit_valid=0 SHALL change no counter (stall), however long the stall lasts.
REQ-014 When the 2^WIDTH-th valid bit is sampled, the FSM SHALL enter DONE on that edge.
REQ-015 The ones-counter SHALL be WIDTH+1 bits so that a count of 2^WIDTH does not overflow.
REQ-016 On entering DONE, value SHALL load min(ones, 2^WIDTH-1); a full-ones window saturates to all-ones.
REQ-017 done SHALL be high for exactly the one cycle spent in DONE; DONE SHALL return to IDLE unconditionally.
REQ-018 Latency SHALL be as follows: done asserts one cycle after the edge that samples the last valid bit.
- With no stalls, done asserts 2^WIDTH+1 cycles after the start cycle.
REQ-019 start SHALL be ignored in RUN and in DONE; a new window requires start in IDLE.
REQ-020 busy SHALL equal (state==RUN).
REQ-021 bit_in and bit_valid SHALL be ignored outside RUN.
REQ-022 value SHALL change only on entry to DONE or on reset.

Reset
REQ-023 rst=1 SHALL force IDLE and clear both counters, value, busy and done.
- This takes effect immediately and asynchronously, including mid-window.
REQ-024 A window aborted by reset SHALL produce no done pulse, and value SHALL read 0.
REQ-025 After rst deasserts, the block SHALL idle until the next start.

Structure
REQ-026 Shared package sc_pkg SHALL hold the WIDTH default and the FSM state enum (IDLE/RUN/DONE).
- sc_pkg is also used by the SNG side of the codebase.
REQ-027 One sub-module, sc_window_counter, SHALL be used: a WIDTH+1-bit counter with clear, enable and terminal-count flag.
- It is instantiated twice, once for the window count and once for the ones count.
- All other logic is inline.

Verification (WIDTH=8)
REQ-028 start, then 256 valid bits all 1 -> done at start+257 cycles, value=255 (saturated), busy high for 256 cycles.
REQ-029 start, then 256 valid bits all 0 -> value=0, done single-cycle.
REQ-030 start, then alternating 1/0 with bit_valid toggling every cycle (stalls) -> value=128, done at start+513 cycles.
REQ-031 start asserted again 10 cycles into RUN, with a 0x40-probability stream -> window is not restarted and value=64.
REQ-032 rst pulsed at bit 100 of a window -> immediate IDLE, busy=0, value=0, no done.
- A following start with 200 ones then 56 zeros -> value=200.
REQ-033 Loop-back: an 8-bit LFSR comparator SNG with input_b=0xB3 feeds bit_in -> value within ±12 of 179.
